// File: rtl/mat_tile_loader.sv
// ---------------------------------------------------------------------------
// mat_tile_loader
//   Producer side of the matrix-multiply operand interface. On start, fetches
//   num_tiles pairs of NxN signed tiles (A then B) one element at a time from a
//   word-serial read port. Each complete pair is presented on matrix_1 /
//   matrix_2 with a one-cycle valid_out strobe.
//
// Ports
//   clk, resetn        clock; asynchronous reset, asserted HIGH
//   start              begin a job (sampled only in IDLE)
//   base_a, base_b     element address of A/B tile 0, element [0][0]
//   num_tiles          number of tile pairs in the job
//   rd_req/rd_addr     read request; address stable while rd_req is high
//   rd_ready           request accepted on rd_req & rd_ready
//   rd_valid/rd_data   in-order read response, one outstanding read max
//   valid_out          one-cycle strobe, matrix_1/matrix_2 hold a full pair
//   matrix_1/matrix_2  A/B tile, packed [row][col][bit]
//   busy, done         job in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------

// One tile element slot: loads rd_data when its lane is selected.
module mat_tile_elem #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge resetn)
    if (resetn)  q <= '0;
    else if (we) q <= d;
endmodule

module mat_tile_loader #(
  parameter int W_IN   = 8,
  parameter int N      = 2,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_a,
  input  logic [ADDR_W-1:0]     base_b,
  input  logic [CNT_W-1:0]      num_tiles,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_ready,
  input  logic                  rd_valid,
  input  logic [W_IN-1:0]       rd_data,
  output logic                  valid_out,
  output logic [N*N*W_IN-1:0]   matrix_1,
  output logic [N*N*W_IN-1:0]   matrix_2,
  output logic                  busy,
  output logic                  done
);
  localparam int NN    = N * N;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NN - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0]  T_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_A, S_WAIT_A, S_REQ_B, S_WAIT_B, S_ISSUE, S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   t, nt;
  // Tiles are contiguous, so a running pointer equals base + t*N*N + idx
  // (wrapping modulo 2^ADDR_W) without a multiplier.
  logic [ADDR_W-1:0]  a_ptr, b_ptr;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      t         <= '0;
      nt        <= '0;
      a_ptr     <= '0;
      b_ptr     <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          nt    <= num_tiles;
          a_ptr <= base_a;
          b_ptr <= base_b;
          t     <= '0;
          idx   <= '0;
          if (num_tiles == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state   <= S_REQ_A;
            busy    <= 1'b1;
            rd_req  <= 1'b1;
            rd_addr <= base_a;
          end
        end
        S_REQ_A: if (rd_ready) begin
          rd_req <= 1'b0;
          a_ptr  <= a_ptr + A_ONE;
          state  <= S_WAIT_A;
        end
        S_WAIT_A: if (rd_valid) begin
          rd_req <= 1'b1;
          if (idx == IDX_LAST) begin
            idx     <= '0;
            rd_addr <= b_ptr;
            state   <= S_REQ_B;
          end else begin
            idx     <= idx + IDX_ONE;
            rd_addr <= a_ptr;
            state   <= S_REQ_A;
          end
        end
        S_REQ_B: if (rd_ready) begin
          rd_req <= 1'b0;
          b_ptr  <= b_ptr + A_ONE;
          state  <= S_WAIT_B;
        end
        S_WAIT_B: if (rd_valid) begin
          if (idx == IDX_LAST) begin
            idx       <= '0;
            valid_out <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            idx     <= idx + IDX_ONE;
            rd_req  <= 1'b1;
            rd_addr <= b_ptr;
            state   <= S_REQ_B;
          end
        end
        S_ISSUE: begin
          t <= t + T_ONE;
          if (t + T_ONE == nt) begin
            // busy drops so it is already low during the done cycle
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= a_ptr;
            state   <= S_REQ_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Element idx = row*N + col lives at bits [idx*W_IN +: W_IN], giving the
  // [row][col][bit] packing. Slots only load in their WAIT state, so a stray
  // rd_valid elsewhere never disturbs the held tiles.
  logic [NN-1:0] we_a, we_b;

  generate
    for (genvar i = 0; i < NN; i++) begin : g_lane
      assign we_a[i] = (state == S_WAIT_A) && rd_valid && (idx == IDX_W'(i));
      assign we_b[i] = (state == S_WAIT_B) && rd_valid && (idx == IDX_W'(i));

      mat_tile_elem #(.W(W_IN)) u_a (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_a[i]),
        .d      (rd_data),
        .q      (matrix_1[i*W_IN +: W_IN])
      );

      mat_tile_elem #(.W(W_IN)) u_b (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_b[i]),
        .d      (rd_data),
        .q      (matrix_2[i*W_IN +: W_IN])
      );
    end
  endgenerate
endmodule

// File: tb/tb_mat_tile_loader.sv
// Directed bench for mat_tile_loader (N=2, W_IN=8, ADDR_W=16, CNT_W=8).
module tb_mat_tile_loader;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] base_a, base_b;
  logic [7:0]  num_tiles;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        valid_out;
  logic [31:0] matrix_1, matrix_2;
  logic        busy, done;

  mat_tile_loader #(.W_IN(8), .N(2), .ADDR_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_a    (base_a),
    .base_b    (base_b),
    .num_tiles (num_tiles),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .valid_out (valid_out),
    .matrix_1  (matrix_1),
    .matrix_2  (matrix_2),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory image and control (written only by the stimulus block)
  logic [7:0] mem [0:65535];
  logic       stall_mode = 1'b0;
  logic       force_valid = 1'b0;

  // monitor state (written only by the monitor)
  int          cyc = 0;
  logic [15:0] addr_q[$];
  logic [31:0] vo_m1[$], vo_m2[$];
  int          vo_cnt = 0, vo_cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int          stall_seen = 0, stall_bad = 0;
  logic        stall_pend = 1'b0;
  logic [15:0] stall_addr = '0;
  logic        acc_q = 1'b0;
  logic [15:0] acc_addr = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd_req && rd_ready) addr_q.push_back(rd_addr);
    if (valid_out) begin
      vo_cnt++;
      vo_cyc = cyc;
      vo_m1.push_back(matrix_1);
      vo_m2.push_back(matrix_2);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (stall_pend && !resetn && (!rd_req || rd_addr !== stall_addr)) stall_bad++;
    stall_pend = rd_req && !rd_ready;
    if (stall_pend) stall_seen++;
    stall_addr = rd_addr;
    acc_q    = rd_req && rd_ready && !resetn;
    acc_addr = rd_addr;
  end

  // one-cycle memory: response the cycle after acceptance
  always @(negedge clk) begin
    rd_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_valid = acc_q | force_valid;
    rd_data  = mem[acc_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tile(input logic [15:0] base);
    logic [31:0] r;
    logic [15:0] a;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = base + 16'(i);
      r[i*8 +: 8] = mem[a];
    end
    return r;
  endfunction

  int a0, v0, d0, b0, s0, s_cyc, errs;
  logic [15:0] ea;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    mem[16'h10] = 8'd1; mem[16'h11] = 8'd2; mem[16'h12] = 8'd3; mem[16'h13] = 8'd4;
    mem[16'h20] = 8'd5; mem[16'h21] = 8'hFA; mem[16'h22] = 8'd7; mem[16'h23] = 8'hF8;
    resetn = 1'b1; start = 1'b0; base_a = '0; base_b = '0; num_tiles = '0;
    rd_ready = 1'b1; rd_valid = 1'b0; rd_data = '0;

    // reset then idle
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_rd_req", rd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_matrices", {matrix_1, matrix_2}, 64'h0);
    check("rst_rd_addr", rd_addr, 0);

    // single tile, 1-cycle memory
    a0 = addr_q.size(); v0 = vo_cnt; d0 = done_cnt; b0 = busy_cnt;
    base_a = 16'h10; base_b = 16'h20; num_tiles = 8'd1; start = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && done_cnt < d0 + 1; k++) @(negedge clk);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_addr_count", addr_q.size() - a0, 8);
    for (int i = 0; i < 8; i++)
      check("t1_addr", (a0 + i < addr_q.size()) ? addr_q[a0+i] : 16'hDEAD,
            (i < 4) ? 16'h10 + 16'(i) : 16'h20 + 16'(i - 4));
    check("t1_vo_count", vo_cnt - v0, 1);
    check("t1_vo_latency", vo_cyc - s_cyc, 17);
    check("t1_done_latency", done_cyc - s_cyc, 18);
    check("t1_busy_cycles", busy_cnt - b0, 17);
    check("t1_matrix_1", matrix_1, 32'h04030201);
    check("t1_matrix_2", matrix_2, 32'hF807FA05);

    // three tiles with random rd_ready stalls, plus start while busy
    @(negedge clk);
    stall_mode = 1'b1;
    a0 = addr_q.size(); v0 = vo_cnt; d0 = done_cnt; s0 = stall_seen;
    base_a = 16'h100; base_b = 16'h200; num_tiles = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    base_a = 16'h300; base_b = 16'h400; num_tiles = 8'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 2000 && done_cnt < d0 + 1; k++) @(negedge clk);
    stall_mode = 1'b0;
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_vo_count", vo_cnt - v0, 3);
    check("t2_addr_count", addr_q.size() - a0, 24);
    errs = 0;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 8; i++) begin
        ea = (i < 4) ? 16'h100 + 16'(4*t + i) : 16'h200 + 16'(4*t + i - 4);
        if (a0 + 8*t + i >= addr_q.size() || addr_q[a0 + 8*t + i] !== ea) errs++;
      end
    check("t2_addr_seq_errs", errs, 0);
    for (int t = 0; t < 3; t++) begin
      check("t2_matrix_1", (v0 + t < vo_m1.size()) ? vo_m1[v0+t] : 32'hDEAD,
            tile(16'h100 + 16'(4*t)));
      check("t2_matrix_2", (v0 + t < vo_m2.size()) ? vo_m2[v0+t] : 32'hDEAD,
            tile(16'h200 + 16'(4*t)));
    end
    check("t2_stalls_seen", stall_seen > s0, 1);
    check("t2_stall_addr_bad", stall_bad, 0);

    // zero tiles; start held through the done cycle must not restart
    @(negedge clk);
    a0 = addr_q.size(); v0 = vo_cnt; d0 = done_cnt; b0 = busy_cnt;
    base_a = 16'h10; base_b = 16'h20; num_tiles = 8'd0; start = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_done_latency", done_cyc - s_cyc, 1);
    check("t3_no_rd_req", addr_q.size() - a0, 0);
    check("t3_no_valid_out", vo_cnt - v0, 0);
    check("t3_busy_cycles", busy_cnt - b0, 0);
    check("t3_matrix_1_held", matrix_1, tile(16'h108));

    // address wrap
    a0 = addr_q.size(); d0 = done_cnt;
    base_a = 16'hFFFE; base_b = 16'h0040; num_tiles = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && done_cnt < d0 + 1; k++) @(negedge clk);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_addr_a", (a0 + 3 < addr_q.size()) ?
          {addr_q[a0], addr_q[a0+1], addr_q[a0+2], addr_q[a0+3]} : 64'hDEAD,
          64'hFFFE_FFFF_0000_0001);
    check("t4_matrix_1", matrix_1, tile(16'hFFFE));
    check("t4_matrix_2", matrix_2, tile(16'h0040));

    // reset while waiting on the first B element
    a0 = addr_q.size(); v0 = vo_cnt; d0 = done_cnt;
    base_a = 16'h10; base_b = 16'h20; num_tiles = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && addr_q.size() < a0 + 5; k++) @(negedge clk);
    check("t5_reached_wait_b", addr_q.size() - a0, 5);
    resetn = 1'b1;
    #1;
    check("t5_async_matrices", {matrix_1, matrix_2}, 64'h0);
    check("t5_async_ctrl", {rd_req, busy, valid_out, done}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b0; force_valid = 1'b1;
    repeat (2) @(negedge clk);
    force_valid = 1'b0;
    @(negedge clk);
    check("t5_late_valid_ignored", {matrix_1, matrix_2}, 64'h0);
    check("t5_idle_after_reset", {busy, rd_req}, 0);
    check("t5_no_strobe", vo_cnt - v0, 0);
    d0 = done_cnt;
    base_a = 16'h100; base_b = 16'h200; num_tiles = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && done_cnt < d0 + 1; k++) @(negedge clk);
    check("t5_new_done", done_cnt - d0, 1);
    check("t5_new_matrix_1", matrix_1, tile(16'h100));
    check("t5_new_matrix_2", matrix_2, tile(16'h200));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mat_tile_loader.md
Name: mat_tile_loader

Overview:
- Producer side of the matrix-multiply operand interface.
- On `start`, fetches `num_tiles` pairs of NxN signed operand tiles (A, B) element-by-element from a word-serial memory read port.
- Assembles each pair into packed matrices and presents them with a one-cycle `valid_out` strobe.
- Sits between the operand scratchpad and the multiply/accumulate array, so consecutive tile pairs accumulate into one result.

Parameters:
- W_IN, 8, element width in bits (signed two's complement).
- N, 2, tile dimension (NxN); N >= 2.
- ADDR_W, 16, memory address width (element-addressed).
- CNT_W, 8, width of the tile-count input.

Ports:
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  reset, asynchronous, active-high (asserted = 1 despite the name).
- start  input  1  begin a job; sampled only in IDLE.
- base_a  input  ADDR_W  address of element [0][0] of A tile 0.
- base_b  input  ADDR_W  address of element [0][0] of B tile 0.
- num_tiles  input  CNT_W  number of tile pairs to issue.
- rd_req  output  1  memory read request.
- rd_addr  output  ADDR_W  memory read address, valid while rd_req = 1.
- rd_ready  input  1  memory accepts request when rd_req & rd_ready.
- rd_valid  input  1  read data valid, at least 1 cycle after acceptance, in order.
- rd_data  input  W_IN  read data.
- valid_out  output  1  one-cycle strobe: matrix_1/matrix_2 hold a complete tile pair.
- matrix_1  output  N*N*W_IN  A tile, packed [row][col][bit], signed.
- matrix_2  output  N*N*W_IN  B tile, same packing.
- busy  output  1  high from job start until done.
- done  output  1  one-cycle pulse at job completion.

Behaviour:
- Reset (any time, including mid-job): all outputs 0, matrices 0, counters 0, FSM = IDLE. Any in-flight read response is discarded; rd_valid is ignored unless in WAIT_A/WAIT_B.
- Tile layout: element idx (0..N*N-1) is row-major, with row = idx / N and col = idx % N.
  - A address = base_a + t*N*N + idx; B address = base_b + t*N*N + idx.
  - Address arithmetic is modulo 2^ADDR_W (wraps silently).
- Registers job-scoped: base_a, base_b and num_tiles are latched on start; later input changes have no effect.
- FSM states: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, ISSUE, DONE.
  - IDLE: busy = 0. On start = 1, latch inputs and set t = 0, idx = 0.
    - If num_tiles == 0, go to DONE.
    - Otherwise go to REQ_A.
  - REQ_A: rd_req = 1, rd_addr = A address.
    - On rd_ready, go to WAIT_A.
    - Otherwise hold; rd_addr stays stable.
  - WAIT_A: rd_req = 0. On rd_valid, write rd_data into the A element at [row][col].
    - If idx == N*N-1, set idx = 0 and go to REQ_B.
    - Otherwise idx++ and go to REQ_A.
  - REQ_B / WAIT_B: same as REQ_A / WAIT_A with the B address, writing matrix_2.
    - After the last element, go to ISSUE.
  - ISSUE: valid_out = 1 for exactly this cycle. t++.
    - If t+1 == num_tiles, go to DONE.
    - Otherwise go to REQ_A.
  - DONE: done = 1 for one cycle, busy = 0, then IDLE.
- Only one read is outstanding at a time.
- matrix_1 and matrix_2 change only while their element is being written. Each retains its last issued tile until overwritten, including after done.
- Partial tiles are never strobed: valid_out is asserted only in ISSUE.
- start is ignored while busy. start in the same cycle as done is ignored; it is accepted the following cycle.
- Throughput with a 1-cycle memory (rd_ready = 1, rd_valid the cycle after acceptance):
  - 2 cycles per element, plus 1 ISSUE cycle, gives 4*N*N + 1 cycles per tile pair (17 at N = 2).
  - Job latency from start to done = 1 + num_tiles*(4*N*N + 1) cycles.
- busy is high from the cycle after start is accepted through the cycle before done. For num_tiles = 0, busy stays 0 and done pulses the cycle after start.

Test Plan:
- Reset then idle: resetn = 1 for 3 cycles, release -> all outputs 0, busy = 0, no rd_req.
- Single tile, N = 2, 1-cycle memory, mem[0x10..0x13] = {1,2,3,4}, mem[0x20..0x23] = {5,-6,7,-8}, base_a = 0x10, base_b = 0x20, num_tiles = 1 -> rd_addr sequence 10,11,12,13,20,21,22,23.
  - valid_out pulses once, 17 cycles after start, with matrix_1 = [[1,2],[3,4]] and matrix_2 = [[5,-6],[7,-8]].
  - done follows next cycle.
- num_tiles = 3 with rd_ready randomly deasserted (~50%) -> exactly 3 valid_out strobes; A tiles come from base_a, base_a+4, base_a+8; rd_addr stable while stalled.
- num_tiles = 0 -> no rd_req, no valid_out, done pulses 1 cycle after start; start asserted during a busy job -> no effect on addresses or tile count.
- Address wrap: base_a = 0xFFFE, num_tiles = 1 -> A addresses FFFE, FFFF, 0000, 0001.
- Reset asserted mid-job while in WAIT_B -> outputs zeroed immediately (asynchronously), a late rd_valid is ignored, and a new job after reset issues correct tiles.
